// File: rtl/call_stack_p_if.sv
// rtl/call_stack_p_if.sv - control/data bundle for the parametrised return-address stack
interface call_stack_p_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             en;
    logic             push;
    logic             pop;
    logic             flush;
    logic             clr_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output en, push, pop, flush, clr_err, data_in,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  en, push, pop, flush, clr_err, data_in,
        output data_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack_p.sv
// rtl/call_stack_p.sv - parametrised return-address stack with registered top-of-stack
module call_stack_p #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    call_stack_p_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, wp_n, wp_dec;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] tos, tos_n;
    logic             ovf, udf;
    logic             ovf_ev, udf_ev;
    logic             wr_en;
    logic             is_empty, is_full;
    logic             do_rep, do_push, do_pop;

    assign wp_dec   = wp - PW'(1);
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_FULL);
    assign do_rep   = bus.en & bus.push & bus.pop;
    assign do_push  = bus.en & bus.push & ~bus.pop;
    assign do_pop   = bus.en & bus.pop & ~bus.push;

    always_comb begin
        wp_n   = wp;
        cnt_n  = cnt;
        tos_n  = tos;
        wr_en  = 1'b0;
        ovf_ev = 1'b0;
        udf_ev = 1'b0;
        if (bus.flush) begin
            cnt_n = '0;
            tos_n = '0;
        end else if (do_rep) begin
            tos_n = bus.data_in;
            if (is_empty) begin
                cnt_n = CW'(1);
            end
        end else if (do_push) begin
            if (is_full && (WRAP_MODE == 0)) begin
                ovf_ev = 1'b1;
            end else begin
                tos_n = bus.data_in;
                // An empty stack has no meaningful tos to spill into the array
                if (!is_empty) begin
                    wr_en = 1'b1;
                    wp_n  = wp + PW'(1);
                end
                if (is_full) begin
                    ovf_ev = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end else if (do_pop) begin
            if (is_empty) begin
                udf_ev = 1'b1;
            end else if (cnt == CW'(1)) begin
                cnt_n = '0;
                tos_n = '0;
            end else begin
                wp_n  = wp_dec;
                tos_n = mem[wp_dec];
                cnt_n = cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            cnt <= '0;
            tos <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            wp  <= wp_n;
            cnt <= cnt_n;
            tos <= tos_n;
            // A new error event outranks a coincident clear
            ovf <= (ovf & ~bus.clr_err) | ovf_ev;
            udf <= (udf & ~bus.clr_err) | udf_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= tos;
        end
    end

    assign bus.data_out  = tos;
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf;
    assign bus.underflow = udf;
endmodule

// File: doc/call_stack_p.md
Name: call_stack_p

Overview:
- Parametrised hardware return-address stack for NeonFox-class CPU front ends.
- Replaces the fixed 16x32 call stack.
- Configurable width and depth, with a selectable overflow policy (wrap or reject).
- Adds explicit occupancy, full/empty status, sticky overflow/underflow error flags, a same-cycle push+pop replace, and a synchronous flush for pipeline recovery.
- Top-of-stack is held in a register, so data_out is valid every cycle without a read-latency bubble.

Parameters:
- WIDTH, 32, bits per entry.
- DEPTH, 16, number of entries; power of two, >= 2.
- WRAP_MODE, 1, 1 = push when full overwrites the oldest entry (circular); 0 = push when full is rejected.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  qualifies push/pop; when 0, the stack state is frozen (flush and clr_err still act).
- push  in  1  push data_in (qualified by en).
- pop  in  1  pop top entry (qualified by en).
- flush  in  1  synchronous empty; highest priority.
- clr_err  in  1  clears overflow/underflow sticky flags.
- data_in  in  WIDTH  value to push.
- data_out  out  WIDTH  current top of stack; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push occurred while full with no simultaneous pop.
- underflow  out  1  sticky: a pop occurred while empty with no simultaneous push.

Behaviour:
- Reset (rst_n low, async):
  - count = 0, write pointer = 0, data_out = 0.
  - overflow = 0, underflow = 0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Structure: entries below the top live in an array indexed by a log2(DEPTH)-bit circular pointer; the top lives in the tos register that drives data_out.
- All updates take effect at the clk edge and are visible the next cycle (1-cycle latency from op to data_out/count).
- Priority per edge: flush > (en & push & pop) > (en & push) > (en & pop).
  - flush: count = 0, data_out = 0. Flags are untouched except by clr_err.
  - push & pop (replace):
    - Non-empty: tos = data_in, count unchanged, no flag change (including when full).
    - Empty: behaves as a plain push (count = 1, tos = data_in), no underflow.
  - push only, not full: old tos is written to the array at the pointer, pointer+1, tos = data_in, count+1.
  - push only, full, WRAP_MODE=1: same as a non-full push, but count stays DEPTH and the oldest entry is silently overwritten (pointer wraps mod DEPTH). overflow sets.
  - push only, full, WRAP_MODE=0: push ignored, all state unchanged. overflow sets.
  - pop only, count > 1: pointer-1, tos = array[pointer-1], count-1.
  - pop only, count == 1: count = 0, data_out = 0.
  - pop only, empty: no state change. underflow sets.
  - After a wrap, up to DEPTH most-recent values pop back in LIFO order. Pops beyond that return underflow once count reaches 0; no stale data is exposed.
- Flags:
  - overflow and underflow remain set until clr_err.
  - If clr_err coincides with a new error event, the set wins.
- en=0: push/pop ignored; flush and clr_err still act.
- empty and full are decoded from registered count (no combinational path from inputs).
- Arithmetic: pointer is mod DEPTH; count saturates at DEPTH and never goes below 0.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 → count=3, data_out=0x300; pop x3 → data_out 0x200, 0x100, 0 (empty=1), underflow=0.
- DEPTH=4, WRAP_MODE=1: push 1..6 → full=1, count=4, overflow=1; pop x4 → 6,5,4,3 visible in turn; 5th pop → underflow=1, count=0.
- DEPTH=4, WRAP_MODE=0: push 1..5 → count=4, overflow=1, data_out=4; pops return 4,3,2,1.
- Push 0xA, then push+pop with data_in 0xB → count=1, data_out=0xB. Push+pop on empty with 0xC → count=1, data_out=0xC, underflow=0.
- Push 3 values, assert flush together with push → count=0, data_out=0. Then clr_err together with pop-on-empty → underflow=1 (set wins); clr_err alone → underflow=0.
- Drive rst_n low asynchronously between edges while count=2 → count=0, data_out=0, flags=0 immediately, before the next clk edge. With en=0, push/pop pulses cause no change.
